// File: rtl/inst_encoder_if.sv
// Request/response bundle for inst_encoder: request fields in, encoded FIFO head and statistics out.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  modport master (
    output in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err, enc_count, err_count
  );

  modport slave (
    input  in_valid, fmt, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_inst, out_err, enc_count, err_count
  );
endinterface

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs register/immediate fields with range checking,
// buffers results in a DEPTH-entry FIFO and keeps accept/error statistics.
module inst_encoder #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  inst_encoder_if.slave  bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam int          DATA_W   = 32;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_S     = 7'b0100011;
  localparam logic [6:0]  OP_B     = 7'b1100011;
  localparam logic [6:0]  OP_U     = 7'b0110111;
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic sext_ok(input logic [31:0] v, input int msb);
    logic [31:0] hi;
    hi = v >> msb;
    return (hi == 32'h0) || (hi == ({32{1'b1}} >> msb));
  endfunction

  logic [DATA_W-1:0] raw_inst_p0;
  logic [DATA_W-1:0] enc_inst_p0;
  logic              legal_p0;
  logic              enc_err_p0;

  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic              err_mem  [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       count;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;

  // Stage p0: combinational encode and legality check of the presented request
  always_comb begin
    raw_inst_p0 = NOP;
    legal_p0    = 1'b0;
    case (bus.fmt)
      3'd0: begin
        raw_inst_p0 = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_R};
        legal_p0    = 1'b1;
      end
      3'd1: begin
        raw_inst_p0 = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_I};
        legal_p0    = sext_ok(bus.imm, 11);
      end
      3'd2: begin
        raw_inst_p0 = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, OP_I};
        legal_p0    = (bus.imm[31:5] == 27'd0) &&
                      ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b101));
      end
      3'd3: begin
        raw_inst_p0 = {bus.imm[11:0], bus.rs1, 3'b011, bus.rd, OP_I};
        legal_p0    = (bus.imm[31:12] == 20'd0);
      end
      3'd4: begin
        raw_inst_p0 = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], OP_S};
        legal_p0    = sext_ok(bus.imm, 11);
      end
      3'd5: begin
        raw_inst_p0 = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                       bus.imm[4:1], bus.imm[11], OP_B};
        legal_p0    = sext_ok(bus.imm, 12) && !bus.imm[0];
      end
      3'd6: begin
        raw_inst_p0 = {bus.imm[31:12], bus.rd, OP_U};
        legal_p0    = (bus.imm[11:0] == 12'd0);
      end
      default: begin
        raw_inst_p0 = NOP;
        legal_p0    = 1'b0;
      end
    endcase
    enc_inst_p0 = legal_p0 ? raw_inst_p0 : NOP;
    enc_err_p0  = !legal_p0;
  end

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  // in_ready is gated by rst_n so nothing can be offered while reset is held
  assign bus.in_ready  = rst_n && !full;
  assign bus.out_valid = !empty;
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Stage p1: FIFO storage, data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wptr] <= enc_inst_p0;
      err_mem[wptr]  <= enc_err_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      bus.enc_count <= 16'd0;
      bus.err_count <= 8'd0;
    end else begin
      if (push) begin
        wptr          <= wptr + PTR_ONE;
        bus.enc_count <= bus.enc_count + 16'd1;
        if (enc_err_p0) bus.err_count <= sat_inc8(bus.err_count);
      end
      if (pop) rptr <= rptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign bus.out_inst = empty ? '0   : inst_mem[rptr];
  assign bus.out_err  = empty ? 1'b0 : err_mem[rptr];
endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: encodings, range errors, FIFO backpressure, streaming and reset.
module tb_inst_encoder;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  int   exp_enc;
  int   exp_err;

  inst_encoder_if bus ();

  inst_encoder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [2:0]  fmt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(string tag, logic [2:0] fmt, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                              logic [31:0] imm, logic [31:0] inst, logic err);
    vec_t v;
    v.tag = tag; v.fmt = fmt; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.inst = inst; v.err = err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.fmt    = v.fmt;
    bus.rd     = v.rd;
    bus.rs1    = v.rs1;
    bus.rs2    = v.rs2;
    bus.funct3 = v.f3;
    bus.funct7 = v.f7;
    bus.imm    = v.imm;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    chk({v.tag, ".rdy"}, bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    exp_enc++;
    if (v.err) exp_err++;
    chk({v.tag, ".vld"}, bus.out_valid, 1);
    chk({v.tag, ".inst"}, bus.out_inst, v.inst);
    chk({v.tag, ".err"}, bus.out_err, v.err);
    chk({v.tag, ".enc"}, bus.enc_count, exp_enc);
    chk({v.tag, ".errcnt"}, bus.err_count, exp_err);
    tick();
    chk({v.tag, ".drained"}, bus.out_valid, 0);
  endtask

  logic [31:0] fill_inst [5];
  logic [31:0] strm_inst [4];

  initial begin
    n_cmp = 0; n_bad = 0; exp_enc = 0; exp_err = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.fmt = 3'd0; bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    bus.funct3 = 3'd0; bus.funct7 = 7'd0; bus.imm = 32'd0;

    fill_inst = '{32'h0000_10B7, 32'h0000_2137, 32'h0000_31B7, 32'h0000_4237, 32'h0000_52B7};
    strm_inst = '{32'h0000_6337, 32'h0000_73B7, 32'h0000_8437, 32'h0000_94B7};

    vecs.push_back(mk("ialu_m1",   3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0));
    vecs.push_back(mk("b_legal",   3'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0010, 32'h0020_8863, 1'b0));
    vecs.push_back(mk("b_odd",     3'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0011, 32'h0000_0013, 1'b1));
    vecs.push_back(mk("u_legal",   3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 1'b0));
    vecs.push_back(mk("u_low",     3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001, 32'h0000_0013, 1'b1));
    vecs.push_back(mk("r_sub",     3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4031_00B3, 1'b0));
    vecs.push_back(mk("s_pos",     3'd4, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h0000_0008, 32'h0020_A423, 1'b0));
    vecs.push_back(mk("s_neg",     3'd4, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0));
    vecs.push_back(mk("srai",      3'd2, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'h0000_0003, 32'h4031_5093, 1'b0));
    vecs.push_back(mk("sh_f3",     3'd2, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'h0000_0003, 32'h0000_0013, 1'b1));
    vecs.push_back(mk("sh_big",    3'd2, 5'd1, 5'd2, 5'd0, 3'd1, 7'h00, 32'h0000_0020, 32'h0000_0013, 1'b1));
    vecs.push_back(mk("sltiu",     3'd3, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'h0000_0FFF, 32'hFFF1_3093, 1'b0));
    vecs.push_back(mk("sltiu_big", 3'd3, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'h0000_1000, 32'h0000_0013, 1'b1));
    vecs.push_back(mk("ialu_rng",  3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0000_0013, 1'b1));
    vecs.push_back(mk("ialu_min",  3'd1, 5'd1, 5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8001_0093, 1'b0));
    vecs.push_back(mk("b_neg",     3'd5, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'hFFFF_FFF8, 32'hFE20_9CE3, 1'b0));
    vecs.push_back(mk("b_rng",     3'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_1000, 32'h0000_0013, 1'b1));
    vecs.push_back(mk("illegal",   3'd7, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_0013, 1'b1));

    // Reset state
    tick(); tick();
    chk("rst.in_ready", bus.in_ready, 0);
    chk("rst.out_valid", bus.out_valid, 0);
    chk("rst.out_inst", bus.out_inst, 0);
    chk("rst.out_err", bus.out_err, 0);
    chk("rst.enc", bus.enc_count, 0);
    chk("rst.err", bus.err_count, 0);
    rst_n = 1'b1;
    #1;
    chk("rel.in_ready", bus.in_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: fill to DEPTH, hold the extra request, then drain in order
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(mk("fill", 3'd6, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'h00, 32'(i + 1) << 12, 32'h0, 1'b0));
      bus.in_valid = 1'b1;
      chk("fill.rdy", bus.in_ready, 1);
      tick();
      exp_enc++;
    end
    drive(mk("extra", 3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_5000, 32'h0, 1'b0));
    chk("full.rdy", bus.in_ready, 0);
    chk("full.enc", bus.enc_count, exp_enc);
    tick(); tick();
    chk("hold.rdy", bus.in_ready, 0);
    chk("hold.vld", bus.out_valid, 1);
    chk("hold.inst", bus.out_inst, fill_inst[0]);
    chk("hold.enc", bus.enc_count, exp_enc);
    bus.out_ready = 1'b1;
    begin
      int  k;
      logic do_push, do_pop;
      k = 0;
      for (int c = 0; c < 20 && k < DEPTH + 1; c++) begin
        do_push = bus.in_valid && bus.in_ready;
        do_pop  = bus.out_valid && bus.out_ready;
        if (do_pop) begin
          chk("drain.inst", bus.out_inst, fill_inst[k]);
          k++;
        end
        tick();
        if (do_push) begin
          bus.in_valid = 1'b0;
          exp_enc++;
        end
      end
      chk("drain.count", k, DEPTH + 1);
    end
    chk("drain.enc", bus.enc_count, exp_enc);
    chk("drain.empty", bus.out_valid, 0);

    // Streaming at occupancy 1, then reset in the middle of it
    for (int i = 0; i < 4; i++) begin
      drive(mk("strm", 3'd6, 5'(i + 6), 5'd0, 5'd0, 3'd0, 7'h00, 32'(i + 6) << 12, 32'h0, 1'b0));
      bus.in_valid = 1'b1;
      chk("strm.rdy", bus.in_ready, 1);
      tick();
      exp_enc++;
      chk("strm.vld", bus.out_valid, 1);
      chk("strm.inst", bus.out_inst, strm_inst[i]);
    end
    chk("strm.enc", bus.enc_count, exp_enc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.vld", bus.out_valid, 0);
    chk("mid.rdy", bus.in_ready, 0);
    chk("mid.inst", bus.out_inst, 0);
    chk("mid.enc", bus.enc_count, 0);
    chk("mid.err", bus.err_count, 0);
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("post.rdy", bus.in_ready, 1);
    tick();
    chk("post.vld", bus.out_valid, 0);
    chk("post.enc", bus.enc_count, 0);

    // First edge after reset release accepts
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive(vecs[0]);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("first.vld", bus.out_valid, 1);
    chk("first.inst", bus.out_inst, 32'hFFF1_0093);
    chk("first.enc", bus.enc_count, 1);
    tick();

    // Error counter saturation with 260 illegal requests streamed
    drive(vecs[vecs.size() - 1]);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    bus.in_valid = 1'b0;
    chk("sat.err", bus.err_count, 8'hFF);
    chk("sat.enc", bus.enc_count, 261);
    chk("sat.out_err", bus.out_err, 1);
    tick();
    chk("sat.empty", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
